// File: rtl/ar_pkg.sv
// ar_pkg: shared state encoding, line-rate constants and parity helper
// for the ARINC-429 transmit scheduler.
package ar_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} ar_state_e;
    localparam int RATE_HS = 100000;
    localparam int RATE_LS = 12500;
    // Bit31 is chosen so the whole 32-bit word carries an odd number of ones.
    function automatic logic [31:0] ar_word(input logic [30:0] w);
        return {~^w, w};
    endfunction
endpackage

// File: rtl/ar_bit_tick.sv
// ar_bit_tick: bit-period prescaler, ce_bit_o pulses once every div_i clocks
// and restarts from zero on a synchronous clear.
module ar_bit_tick #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] div_i,
    output logic         ce_bit_o
);
    logic [W-1:0] cnt_q;

    assign ce_bit_o = cnt_q == div_i - W'(1);

    always_ff @(posedge clk)
        cnt_q <= (rst || clr_i || ce_bit_o) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/ar_tx_sched.sv
// ar_tx_sched: round-robin scheduler feeding one ARINC-429 transmitter, with
// parity insertion, completion timeout and enforced inter-word gap.
module ar_tx_sched
    import ar_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int F_CLK    = 50000000,
    parameter int GAP_BITS = 4,
    parameter int TMO_BITS = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [31*N_REQ-1:0] req_dat,
    output logic [N_REQ-1:0]   req_rdy,
    input  logic               hs,
    output logic [31:0]        tx_dat,
    output logic               tx_st,
    input  logic               tx_done,
    output logic               en_TX,
    output logic [2:0]         gnt_id,
    output logic [15:0]        cnt_tx,
    output logic               err
);
    localparam logic [31:0] DIV_HS = 32'(F_CLK / RATE_HS);
    localparam logic [31:0] DIV_LS = 32'(F_CLK / RATE_LS);
    localparam int BW = $clog2((TMO_BITS > GAP_BITS ? TMO_BITS : GAP_BITS) + 1);

    ar_state_e        state_q;
    logic [2:0]       ptr_q;
    logic [2:0]       gnt_q;
    logic [31:0]      div_q;
    logic [BW-1:0]    bit_q;
    logic [31:0]      tx_dat_q;
    logic             tx_st_q;
    logic             en_q;
    logic             err_q;
    logic [15:0]      cnt_q;
    logic [N_REQ-1:0] req_rdy_q;
    logic [2:0]       sel_d;
    logic [7:0]       vld8;
    logic [30:0]      words [8];
    logic             ce_bit;
    logic             tmo;
    logic             clr;

    assign vld8 = 8'(req_vld);

    for (genvar g = 0; g < 8; g++) begin : g_w
        if (g < N_REQ) begin : g_on
            assign words[g] = req_dat[31*g +: 31];
        end else begin : g_off
            assign words[g] = '0;
        end
    end

    // Scan downward so the requester closest at/after the pointer wins last.
    always_comb begin
        sel_d = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (vld8[3'((int'(ptr_q) + i) % N_REQ)]) sel_d = 3'((int'(ptr_q) + i) % N_REQ);
    end

    assign tmo = ce_bit && bit_q == BW'(TMO_BITS - 1);
    assign clr = state_q == LOAD || (state_q == SEND && (tx_done || tmo));

    ar_bit_tick #(.W(32)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .div_i    (div_q),
        .ce_bit_o (ce_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            div_q     <= DIV_LS;
            bit_q     <= '0;
            tx_dat_q  <= '0;
            tx_st_q   <= 1'b0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            req_rdy_q <= '0;
        end else begin
            tx_st_q   <= 1'b0;
            req_rdy_q <= '0;
            case (state_q)
                IDLE: begin
                    div_q <= hs ? DIV_HS : DIV_LS;
                    if (|req_vld) begin
                        state_q   <= LOAD;
                        tx_dat_q  <= ar_word(words[sel_d]);
                        tx_st_q   <= 1'b1;
                        req_rdy_q <= N_REQ'(1) << sel_d;
                        gnt_q     <= sel_d;
                        ptr_q     <= (int'(sel_d) == N_REQ - 1) ? '0 : sel_d + 3'd1;
                    end
                end
                LOAD: begin
                    state_q <= SEND;
                    en_q    <= 1'b1;
                    bit_q   <= '0;
                end
                SEND: begin
                    if (tx_done || tmo) begin
                        state_q <= GAP;
                        en_q    <= 1'b0;
                        bit_q   <= '0;
                        cnt_q   <= tx_done ? cnt_q + 16'd1 : cnt_q;
                        err_q   <= err_q | ~tx_done;
                    end else if (ce_bit) begin
                        bit_q <= bit_q + BW'(1);
                    end
                end
                default: begin
                    if (ce_bit) begin
                        state_q <= (bit_q == BW'(GAP_BITS - 1)) ? IDLE : GAP;
                        bit_q   <= bit_q + BW'(1);
                    end
                end
            endcase
        end
    end

    assign req_rdy = req_rdy_q;
    assign tx_dat  = tx_dat_q;
    assign tx_st   = tx_st_q;
    assign en_TX   = en_q;
    assign gnt_id  = gnt_q;
    assign cnt_tx  = cnt_q;
    assign err     = err_q;
endmodule

// File: doc/ar_tx_sched.md
Name: ar_tx_sched

Overview:
Round-robin scheduler that shares the single ARINC-429 transmitter among N_REQ word sources.
- Accepts 31-bit words (label + data + SSM) through per-requester valid/ready handshakes.
- Appends odd parity and launches the transmitter.
- Supervises completion with a timeout.
- Enforces the mandatory inter-word gap in bit times.
- Sits between the host/test word generators and the ARINC-429 transmitter in the ARINC test chain.

Parameters:
N_REQ, 4, number of requesters (2..8)
F_CLK, 50000000, clk frequency in Hz
GAP_BITS, 4, minimum inter-word gap in bit periods
TMO_BITS, 40, bit periods allowed between tx_st and tx_done before timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_vld  in  N_REQ  requester i has a word pending
req_dat  in  31*N_REQ  word of requester i in bits [31*i+30:31*i]
req_rdy  out  N_REQ  one-cycle accept pulse for the granted requester
hs  in  1  rate select: 1 = 100 kbit/s, 0 = 12.5 kbit/s
tx_dat  out  32  word to transmitter, bit31 = parity
tx_st  out  1  one-cycle start strobe to transmitter
tx_done  in  1  transmitter end-of-word pulse
en_TX  out  1  transmitter enable, high while a word is in flight
gnt_id  out  3  index of the last granted requester
cnt_tx  out  16  count of words completed with tx_done, wraps at 16'hFFFF -> 0
err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - State IDLE.
  - tx_dat, tx_st, req_rdy, en_TX, gnt_id, cnt_tx, err all 0.
  - Round-robin pointer 0.
  - Prescaler cleared.
- Rate is latched from hs only in IDLE, into the DIV register:
  - hs=1 gives DIV = F_CLK/100000 (500 at default).
  - hs=0 gives DIV = F_CLK/12500 (4000 at default).
  - hs changes during LOAD/SEND/GAP are ignored.
- Bit tick: ce_bit pulses once every DIV clocks. The prescaler is cleared on entry to SEND and on entry to GAP.
- IDLE:
  - If any req_vld is high, select the first set bit at or after the pointer, scanning upward with wrap.
  - Latch that index k and go to LOAD next cycle. Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - tx_dat = {~^w, w}, where w = word k as sampled at the IDLE cycle.
  - Bit31 makes the total number of ones odd.
  - tx_st=1, req_rdy[k]=1, gnt_id=k, pointer = (k+1) mod N_REQ.
  - Go to SEND.
- SEND:
  - en_TX=1; tx_dat held stable.
  - tx_done sampled only in this state.
  - On tx_done: cnt_tx+1, go to GAP.
  - If TMO_BITS ticks elapse without tx_done: err=1, go to GAP, cnt_tx unchanged. The word is dropped, not retried.
  - tx_done and timeout in the same cycle: tx_done wins.
- GAP:
  - en_TX=0; lasts exactly GAP_BITS*DIV cycles, then IDLE.
  - Result: the next tx_st is exactly GAP_BITS*DIV+2 cycles after the tx_done cycle, provided a request is pending.
- Handshake:
  - A requester must hold req_vld and req_dat until its req_rdy pulse.
  - Dropping req_vld before grant is legal and has no effect.
  - At most one req_rdy bit is high in any cycle.
- tx_done in IDLE, LOAD or GAP is ignored.
- err is cleared only by rst.
- rst in any state returns to reset values on the next edge. A word in SEND is abandoned and cnt_tx is not incremented.

Decomposition:
- Package ar_pkg:
  - State encoding (IDLE, LOAD, SEND, GAP).
  - Rate constants RATE_HS=100000 and RATE_LS=12500.
  - Odd-parity function for the 32-bit ARINC word.
- Sub-module ar_bit_tick: prescaler with load value DIV, synchronous clear, ce_bit output.

Test Plan:
- Single word: req_vld=4'b0001, req_dat[30:0]=31'h0 -> one req_rdy[0] pulse, then tx_st with tx_dat=32'h80000000. Next, word 31'h1 -> tx_dat=32'h00000001.
- Round-robin: all four req_vld held high, pointer 0 -> grants in order 0,1,2,3,0. gnt_id follows the same order; no requester granted twice in a row.
- Gap timing: hs=1, two back-to-back requests, tx_done at cycle t -> second tx_st at exactly t+2002. With hs=0 -> t+16002.
- Timeout: hs=1, tx_done never driven -> err=1 exactly 40*500 cycles after SEND entry. Then en_TX=0, cnt_tx unchanged, next request still served.
- Rate latch: toggle hs mid-SEND -> gap uses the old rate; the following word uses the new rate.
- Reset mid-SEND: rst for 1 cycle -> next cycle tx_st=0, en_TX=0, err=0, cnt_tx=0, pointer=0. A later tx_done is ignored.
